// File: rtl/fp_cmp_arb.sv
`default_nettype none
// ============================================================================
// Module      : fp_cmp_arb
// Description : Two-requester arbiter that time-shares one combinational FP
//               comparator; one operation in flight, sticky flag accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_cmp_arb #(
    parameter int RR_EN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [32:0] req0_data1,
    input  logic [32:0] req0_data2,
    input  logic [2:0]  req0_rm,
    input  logic [9:0]  req0_class1,
    input  logic [9:0]  req0_class2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [32:0] req1_data1,
    input  logic [32:0] req1_data2,
    input  logic [2:0]  req1_rm,
    input  logic [9:0]  req1_class1,
    input  logic [9:0]  req1_class2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic [4:0]  rsp0_flags,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [4:0]  rsp1_flags,
    output logic [32:0] cmp_data1,
    output logic [32:0] cmp_data2,
    output logic [2:0]  cmp_rm,
    output logic [9:0]  cmp_class1,
    output logic [9:0]  cmp_class2,
    input  logic [31:0] cmp_result,
    input  logic [4:0]  cmp_flags,
    output logic [4:0]  flags_acc,
    input  logic        flags_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [32:0] r_data1;
    logic [32:0] r_data2;
    logic [2:0]  r_rm;
    logic [9:0]  r_class1;
    logic [9:0]  r_class2;
    logic        r_owner;
    logic [31:0] r_result;
    logic [4:0]  r_flags;
    logic [4:0]  r_flags_acc;
    logic        w_winner;
    logic        w_accept;
    logic        w_rsp_ready;

    // Ready is gated by reset so nothing appears accepted while held in reset.
    assign w_accept = (r_state == IDLE) && (req0_valid || req1_valid) && !reset;

    generate
        if (RR_EN != 0) begin : g_rr
            logic r_last;

            // Contention goes to the requester that was not granted last.
            assign w_winner = (req0_valid && req1_valid) ? ~r_last : req1_valid;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_last <= 1'b1;
                end else if (w_accept) begin
                    r_last <= w_winner;
                end
            end
        end else begin : g_fixed
            assign w_winner = ~req0_valid;
        end
    endgenerate

    assign req0_ready  = w_accept && !w_winner;
    assign req1_ready  = w_accept &&  w_winner;
    assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (w_rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data1  <= '0;
            r_data2  <= '0;
            r_rm     <= '0;
            r_class1 <= '0;
            r_class2 <= '0;
            r_owner  <= 1'b0;
        end else if (w_accept) begin
            r_owner  <= w_winner;
            r_data1  <= w_winner ? req1_data1  : req0_data1;
            r_data2  <= w_winner ? req1_data2  : req0_data2;
            r_rm     <= w_winner ? req1_rm     : req0_rm;
            r_class1 <= w_winner ? req1_class1 : req0_class1;
            r_class2 <= w_winner ? req1_class2 : req0_class2;
        end
    end

    // A clear coinciding with a capture keeps the newly captured flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_flags_acc <= '0;
        end else begin
            if (r_state == EXEC) begin
                r_result <= cmp_result;
                r_flags  <= cmp_flags;
            end
            if (flags_clr) begin
                r_flags_acc <= (r_state == EXEC) ? cmp_flags : 5'd0;
            end else if (r_state == EXEC) begin
                r_flags_acc <= r_flags_acc | cmp_flags;
            end
        end
    end

    assign cmp_data1   = r_data1;
    assign cmp_data2   = r_data2;
    assign cmp_rm      = r_rm;
    assign cmp_class1  = r_class1;
    assign cmp_class2  = r_class2;
    assign rsp0_valid  = (r_state == RESP) && !r_owner;
    assign rsp1_valid  = (r_state == RESP) &&  r_owner;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_flags  = r_flags;
    assign rsp1_flags  = r_flags;
    assign flags_acc   = r_flags_acc;

endmodule
`default_nettype wire
